approx_add_scheduler: RTL and testbench
=======================================

// Module: approx_add_scheduler
// PURPOSE
// Round-robin scheduler that shares one HOAANED approximate adder (N-bit, LPL-bit imprecise LSB part)
// among NREQ requesters. Each request selects approximate or exact addition, and the block returns the tagged N+1-bit sum.
// Sits between client datapaths and the shared adder. Keeps saturating usage counters for accuracy/energy profiling.
// PARAMETERS
// N     16  operand width
// LPL    6  imprecise lower-part length (UPL = N-LPL); requires 3 <= LPL < N
// NREQ   4  number of requesters, 2..16; IDW = $clog2(NREQ)
// CNTW  16  width of usage counters
// PORTS
// clk        in   1          rising-edge clock
// rst_n      in   1          synchronous active-low reset
// req_valid  in   NREQ       request valid, one bit per requester
// req_exact  in   NREQ       1 = exact add, 0 = HOAANED approximate add
// req_a      in   NREQ*N     operand A, requester i at [i*N +: N]
// req_b      in   NREQ*N     operand B, same packing as req_a
// req_ready  out  NREQ       one-hot accept; at most one bit high per cycle
// rsp_valid  out  1          response valid
// rsp_ready  in   1          response consumer ready
// rsp_id     out  IDW        index of the requester that owns rsp_sum
// rsp_exact  out  1          mode used for this response
// rsp_sum    out  N+1        sum with carry-out in bit N
// busy       out  1          high whenever state != IDLE
// approx_cnt out  CNTW       completed approximate ops, saturating
// exact_cnt  out  CNTW       completed exact ops, saturating
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0; all outputs 0, including the counters.
//   Any in-flight or pending response is dropped. Reset overrides every other event in that cycle.
// - FSM states:
//   IDLE -> CALC when any req_valid is high.
//   CALC -> RESP unconditionally.
//   RESP -> IDLE on rsp_valid & rsp_ready.
// - IDLE grant: g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - req_ready[g] = 1 combinationally in IDLE only; the handshake completes in that same cycle.
//   - On the handshake, latch op_a, op_b, id = g and exact = req_exact[g].
// - CALC: approximate sum = HOAANED(op_a, op_b). Exact sum = op_a + op_b, zero-extended to N+1 bits.
//   - Register the sum selected by exact into rsp_sum, together with rsp_id and rsp_exact.
//   - Set rsp_valid = 1.
// - HOAANED arithmetic, with low = op[LPL-1:0]:
//   - c = a[LPL-1] & b[LPL-1].
//   - s[LPL-1] = (~c & (a[LPL-1] | b[LPL-1])) | (a[LPL-2] & b[LPL-2]).
//   - s[LPL-2] = a[LPL-2] | b[LPL-2].
//   - s[LPL-3:0] = 1, i.e. the value 1 zero-extended (bit 0 = 1, other bits 0).
//   - Upper bits: s[N:LPL] = a[N-1:LPL] + b[N-1:LPL] + c, exact ripple add with carry-out.
// - RESP: rsp_valid, rsp_id, rsp_exact and rsp_sum stay stable until accepted.
//   - On acceptance: rsp_valid -> 0, rr_ptr <= (id+1) mod NREQ, and the matching counter increments.
//   - Counters increment unless already at all-ones; they then hold.
// - Timing: accept at cycle T, rsp_valid high from T+2. Peak throughput is 1 op per 3 cycles.
//   No request is accepted while in CALC or RESP.
// - Requester-side rules:
//   - A requester must hold req_valid, req_exact and its operands stable until req_ready.
//   - Dropping req_valid before its grant is legal; the grant then goes elsewhere or is not issued.
// - Fairness: under continuous requests from all requesters, grants rotate 0,1,..,NREQ-1,0.
//   No requester waits more than NREQ-1 grants.
// TESTING
// - Reset mid-op: assert rst_n=0 during RESP -> next cycle rsp_valid=0, busy=0, counters 0, rr_ptr=0;
//   the first grant after reset goes to the lowest valid requester.
// - Req0 approximate, A=0x0000, B=0x0000 -> rsp_sum=0x00001, rsp_id=0, rsp_exact=0, rsp_valid at T+2.
// - Req1 approximate, A=B=0x0020 -> rsp_sum=0x00041. Same operands exact -> rsp_sum=0x00040;
//   approx_cnt=1, exact_cnt=1.
// - Req2 approximate, A=B=0xFFFF -> rsp_sum=0x1FFF1 (carry-out set). Exact -> rsp_sum=0x1FFFE.
// - All four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0.
//   req_ready is one-hot; each accept is spaced 3 cycles apart.
// - rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_sum stay stable, no new req_ready.
//   Preload a counter to 0xFFFF, complete one more op -> the counter stays 0xFFFF.

Source files
------------

// File: rtl/approx_add_scheduler.sv
// Round-robin arbiter sharing one HOAANED approximate / exact adder among
// NREQ requesters, with saturating per-mode usage counters.
module approx_add_scheduler #(
    parameter int N    = 16,
    parameter int LPL  = 6,
    parameter int NREQ = 4,
    parameter int CNTW = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_exact,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_exact,
    output logic [N:0]        rsp_sum,
    output logic              busy,
    output logic [CNTW-1:0]   approx_cnt,
    output logic [CNTW-1:0]   exact_cnt
);

    localparam int UPL = N - LPL;
    localparam logic [LPL-3:0] LOW_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N-1:0]    op_a_q, op_a_d;
    logic [N-1:0]    op_b_q, op_b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            exact_q, exact_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_exact_q, rsp_exact_d;
    logic [N:0]      rsp_sum_q, rsp_sum_d;
    logic [CNTW-1:0] approx_cnt_q, approx_cnt_d;
    logic [CNTW-1:0] exact_cnt_q, exact_cnt_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    int              idx;

    logic            hc;
    logic            s_hi;
    logic            s_mid;
    logic [UPL:0]    upper_sum;
    logic [N:0]      approx_sum;
    logic [N:0]      exact_sum;

    // Search starts at rr_ptr and wraps, so the last served requester goes last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        hc        = op_a_q[LPL-1] & op_b_q[LPL-1];
        s_hi      = (~hc & (op_a_q[LPL-1] | op_b_q[LPL-1]))
                  | (op_a_q[LPL-2] & op_b_q[LPL-2]);
        s_mid     = op_a_q[LPL-2] | op_b_q[LPL-2];
        upper_sum = {1'b0, op_a_q[N-1:LPL]}
                  + {1'b0, op_b_q[N-1:LPL]}
                  + {{UPL{1'b0}}, hc};
        approx_sum = {upper_sum, s_hi, s_mid, LOW_ONE};
        exact_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        exact_d      = exact_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_exact_d  = rsp_exact_q;
        rsp_sum_d    = rsp_sum_q;
        approx_cnt_d = approx_cnt_q;
        exact_cnt_d  = exact_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d = CALC;
                    op_a_d  = req_a[gnt_id*N +: N];
                    op_b_d  = req_b[gnt_id*N +: N];
                    id_d    = gnt_id;
                    exact_d = req_exact[gnt_id];
                end
            end
            CALC: begin
                state_d     = RESP;
                rsp_sum_d   = exact_q ? exact_sum : approx_sum;
                rsp_id_d    = id_q;
                rsp_exact_d = exact_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    if (exact_q) begin
                        if (exact_cnt_q != '1) exact_cnt_d = exact_cnt_q + 1'b1;
                    end else begin
                        if (approx_cnt_q != '1) approx_cnt_d = approx_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            exact_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_exact_q  <= 1'b0;
            rsp_sum_q    <= '0;
            approx_cnt_q <= '0;
            exact_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            exact_q      <= exact_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_exact_q  <= rsp_exact_d;
            rsp_sum_q    <= rsp_sum_d;
            approx_cnt_q <= approx_cnt_d;
            exact_cnt_q  <= exact_cnt_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_exact  = rsp_exact_q;
    assign rsp_sum    = rsp_sum_q;
    assign busy       = (state_q != IDLE);
    assign approx_cnt = approx_cnt_q;
    assign exact_cnt  = exact_cnt_q;

endmodule

// File: tb/tb_approx_add_scheduler.sv
// Directed-vector bench for approx_add_scheduler (N=16, LPL=6, NREQ=4);
// a second instance with 2-bit counters exercises counter saturation.
module tb_approx_add_scheduler;

    localparam int N    = 16;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_exact;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic            rsp_ready;

    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_exact;
    logic [N:0]      rsp_sum;
    logic            busy;
    logic [15:0]     approx_cnt;
    logic [15:0]     exact_cnt;

    logic [NREQ-1:0] s_req_ready;
    logic            s_rsp_valid;
    logic [1:0]      s_rsp_id;
    logic            s_rsp_exact;
    logic [N:0]      s_rsp_sum;
    logic            s_busy;
    logic [1:0]      s_approx_cnt;
    logic [1:0]      s_exact_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    approx_add_scheduler #(.N(16), .LPL(6), .NREQ(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_exact(req_exact),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_exact(rsp_exact), .rsp_sum(rsp_sum),
        .busy(busy), .approx_cnt(approx_cnt), .exact_cnt(exact_cnt)
    );

    approx_add_scheduler #(.N(16), .LPL(6), .NREQ(4), .CNTW(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_exact(req_exact),
        .req_a(req_a), .req_b(req_b), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(s_rsp_id), .rsp_exact(s_rsp_exact), .rsp_sum(s_rsp_sum),
        .busy(s_busy), .approx_cnt(s_approx_cnt), .exact_cnt(s_exact_cnt)
    );

    typedef struct {
        int          id;
        logic        ex;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] sum;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Single-requester op, called just after a posedge with the DUT idle.
    task automatic do_op(input int id, input logic ex, input logic [15:0] a,
                         input logic [15:0] b, input logic [16:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_valid = oh;
        req_exact[id] = ex;
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        @(negedge clk);
        chk("grant", {28'd0, req_ready}, {28'd0, oh});
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("calc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("calc_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_sum", {15'd0, rsp_sum}, {15'd0, exp});
        chk("rsp_id", {30'd0, rsp_id}, id);
        chk("rsp_exact", {31'd0, rsp_exact}, {31'd0, ex});
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 16'h0000, 16'h0000, 17'h00001};
        vecs[1]  = '{1, 1'b0, 16'h0020, 16'h0020, 17'h00041};
        vecs[2]  = '{1, 1'b1, 16'h0020, 16'h0020, 17'h00040};
        vecs[3]  = '{2, 1'b0, 16'hFFFF, 16'hFFFF, 17'h1FFF1};
        vecs[4]  = '{2, 1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        vecs[5]  = '{3, 1'b0, 16'h1234, 16'h0F0F, 17'h02131};
        vecs[6]  = '{3, 1'b1, 16'h1234, 16'h0F0F, 17'h02143};
        vecs[7]  = '{0, 1'b0, 16'h0030, 16'h0010, 17'h00031};
        vecs[8]  = '{1, 1'b0, 16'h8000, 16'h8000, 17'h10001};
        vecs[9]  = '{0, 1'b0, 16'h003F, 16'h0020, 17'h00051};
        vecs[10] = '{3, 1'b0, 16'h0001, 16'h0002, 17'h00001};

        rst_n     = 1'b0;
        req_valid = '0;
        req_exact = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_sum", {15'd0, rsp_sum}, 32'd0);
        chk("rst_approx_cnt", {16'd0, approx_cnt}, 32'd0);
        chk("rst_exact_cnt", {16'd0, exact_cnt}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].id, vecs[i].ex, vecs[i].a, vecs[i].b, vecs[i].sum);
        end

        @(negedge clk);
        chk("approx_cnt", {16'd0, approx_cnt}, 32'd8);
        chk("exact_cnt", {16'd0, exact_cnt}, 32'd3);
        chk("sat_approx_cnt", {30'd0, s_approx_cnt}, 32'd3);
        chk("sat_exact_cnt", {30'd0, s_exact_cnt}, 32'd3);
        @(posedge clk); #1;

        // Response back-pressure, then reset while the response is pending.
        req_valid = 4'b0100;
        req_exact[2] = 1'b1;
        req_a[2*N +: N] = 16'h1234;
        req_b[2*N +: N] = 16'h0F0F;
        @(negedge clk);
        chk("stall_grant", {28'd0, req_ready}, 32'h4);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall_calc_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_sum", {15'd0, rsp_sum}, 32'h02143);
            chk("stall_req_ready", {28'd0, req_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_approx_cnt", {16'd0, approx_cnt}, 32'd0);
        chk("midrst_exact_cnt", {16'd0, exact_cnt}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            req_exact[i] = 1'b1;
            req_a[i*N +: N] = 16'(i * 16'h0111);
            req_b[i*N +: N] = 16'h1000;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Continuous requests from all: grants rotate from 0, one per 3 cycles.
        for (int k = 0; k < 5; k++) begin
            int e;
            logic [3:0] oh;
            e = k % NREQ;
            oh = 4'b0001 << e;
            @(negedge clk);
            chk("rr_grant", {28'd0, req_ready}, {28'd0, oh});
            @(posedge clk);
            @(negedge clk);
            chk("rr_calc_ready", {28'd0, req_ready}, 32'd0);
            chk("rr_calc_valid", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rr_rsp_id", {30'd0, rsp_id}, e);
            chk("rr_rsp_sum", {15'd0, rsp_sum}, 32'h1000 + e * 32'h0111);
            chk("rr_resp_ready", {28'd0, req_ready}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("rr_exact_cnt", {16'd0, exact_cnt}, 32'd5);
        chk("rr_sat_exact_cnt", {30'd0, s_exact_cnt}, 32'd3);
        chk("rr_approx_cnt", {16'd0, approx_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
